// File: rtl/smarthouse_pkg.sv
// Shared smarthouse definitions: command encodings, command lengths and ASCII
// constants used by both the command sender and the character receiver.
package smarthouse_pkg;

    typedef enum logic [1:0] {
        CMD_OPENWINDOW  = 2'd0,
        CMD_CLOSEWINDOW = 2'd1,
        CMD_OPENDOOR    = 2'd2,
        CMD_CLOSEDOOR   = 2'd3
    } cmd_e;

    localparam logic [3:0] LEN_OPENWINDOW  = 4'd10;
    localparam logic [3:0] LEN_CLOSEWINDOW = 4'd11;
    localparam logic [3:0] LEN_OPENDOOR    = 4'd8;
    localparam logic [3:0] LEN_CLOSEDOOR   = 4'd9;

    localparam logic [7:0] ASCII_C = 8'h43;
    localparam logic [7:0] ASCII_D = 8'h44;
    localparam logic [7:0] ASCII_E = 8'h45;
    localparam logic [7:0] ASCII_I = 8'h49;
    localparam logic [7:0] ASCII_L = 8'h4C;
    localparam logic [7:0] ASCII_N = 8'h4E;
    localparam logic [7:0] ASCII_O = 8'h4F;
    localparam logic [7:0] ASCII_P = 8'h50;
    localparam logic [7:0] ASCII_R = 8'h52;
    localparam logic [7:0] ASCII_S = 8'h53;
    localparam logic [7:0] ASCII_W = 8'h57;

    function automatic logic [3:0] cmd_length(input cmd_e c);
        case (c)
            CMD_OPENWINDOW:  return LEN_OPENWINDOW;
            CMD_CLOSEWINDOW: return LEN_CLOSEWINDOW;
            CMD_OPENDOOR:    return LEN_OPENDOOR;
            default:         return LEN_CLOSEDOOR;
        endcase
    endfunction

endpackage

// File: rtl/command_rom.sv
// Combinational character tables: returns the character at position index of
// the selected command; positions past the end read as 8'h00.
module command_rom
    import smarthouse_pkg::*;
(
    input  cmd_e       cmd,
    input  logic [3:0] index,
    output logic [7:0] char
);

    always_comb begin
        char = 8'h00;
        case (cmd)
            CMD_OPENWINDOW: begin
                case (index)
                    4'd0: char = ASCII_O;  4'd1: char = ASCII_P;  4'd2: char = ASCII_E;
                    4'd3: char = ASCII_N;  4'd4: char = ASCII_W;  4'd5: char = ASCII_I;
                    4'd6: char = ASCII_N;  4'd7: char = ASCII_D;  4'd8: char = ASCII_O;
                    4'd9: char = ASCII_W;
                    default: char = 8'h00;
                endcase
            end
            CMD_CLOSEWINDOW: begin
                case (index)
                    4'd0: char = ASCII_C;  4'd1: char = ASCII_L;  4'd2: char = ASCII_O;
                    4'd3: char = ASCII_S;  4'd4: char = ASCII_E;  4'd5: char = ASCII_W;
                    4'd6: char = ASCII_I;  4'd7: char = ASCII_N;  4'd8: char = ASCII_D;
                    4'd9: char = ASCII_O;  4'd10: char = ASCII_W;
                    default: char = 8'h00;
                endcase
            end
            CMD_OPENDOOR: begin
                case (index)
                    4'd0: char = ASCII_O;  4'd1: char = ASCII_P;  4'd2: char = ASCII_E;
                    4'd3: char = ASCII_N;  4'd4: char = ASCII_D;  4'd5: char = ASCII_O;
                    4'd6: char = ASCII_O;  4'd7: char = ASCII_R;
                    default: char = 8'h00;
                endcase
            end
            default: begin
                case (index)
                    4'd0: char = ASCII_C;  4'd1: char = ASCII_L;  4'd2: char = ASCII_O;
                    4'd3: char = ASCII_S;  4'd4: char = ASCII_E;  4'd5: char = ASCII_D;
                    4'd6: char = ASCII_O;  4'd7: char = ASCII_O;  4'd8: char = ASCII_R;
                    default: char = 8'h00;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/command_sender.sv
// Streams the ASCII text of a smarthouse command one character per accepted
// handshake, then pulses done; all outputs come straight from registers.
module command_sender
    import smarthouse_pkg::*;
#(
    parameter logic [7:0] IDLE_CHAR = 8'h00
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] cmd,
    input  logic       char_ready,
    output logic [7:0] char,
    output logic       char_valid,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_e;

    state_e     state, state_next;
    cmd_e       cmd_q, cmd_next;
    logic [3:0] index, index_next;
    logic [7:0] rom_char;
    logic [7:0] char_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            cmd_q      <= CMD_OPENWINDOW;
            index      <= 4'd0;
            char       <= IDLE_CHAR;
            char_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_next;
            cmd_q      <= cmd_next;
            index      <= index_next;
            char       <= char_next;
            char_valid <= (state_next == SEND);
            busy       <= (state_next != IDLE);
            done       <= (state_next == DONE);
        end
    end

    always_comb begin
        state_next = state;
        cmd_next   = cmd_q;
        index_next = index;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = SEND;
                    cmd_next   = cmd_e'(cmd);
                    index_next = 4'd0;
                end
            end
            SEND: begin
                if (char_valid && char_ready) begin
                    if (index == cmd_length(cmd_q) - 4'd1)
                        state_next = DONE;
                    else
                        index_next = index + 4'd1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The ROM looks up the character for the next cycle so it can be registered.
    command_rom rom (
        .cmd   (cmd_next),
        .index (index_next),
        .char  (rom_char)
    );

    assign char_next = (state_next == SEND) ? rom_char : IDLE_CHAR;

endmodule

// File: tb/tb_command_sender.sv
// Self-checking bench for command_sender: table-driven commands with a
// character scoreboard plus hand-written reset and back-to-back sequences.
module tb_command_sender;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] cmd;
    logic       char_ready;
    logic [7:0] char;
    logic       char_valid;
    logic       busy;
    logic       done;

    int tests_run = 0;
    int tests_failed = 0;
    byte unsigned exp_q[$];

    typedef struct {
        logic [1:0] cmd;
        string      text;
        int         ready_mode;
        int         glitch_at;
    } vec_t;

    vec_t vectors[4];

    always #5 clock = ~clock;

    command_sender #(.IDLE_CHAR(8'h00)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .cmd        (cmd),
        .char_ready (char_ready),
        .char       (char),
        .char_valid (char_valid),
        .busy       (busy),
        .done       (done)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] required);
        tests_run++;
        if (actual !== required) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, required);
        end
    endtask

    task automatic push_text(input string t);
        for (int i = 0; i < t.len(); i++) exp_q.push_back(t[i]);
    endtask

    task automatic check_transfer(input string name);
        byte unsigned e;
        if (exp_q.size() == 0) begin
            check_output({name, "_unexpected"}, 32'(char), 32'hFFFF_FFFF);
        end else begin
            e = exp_q.pop_front();
            check_output(name, 32'(char), 32'(e));
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        int         transfers;
        int         busy_cycles;
        bit         finished;
        bit         holding;
        bit         glitched;
        logic [7:0] held;
        logic [79:0] rx_shift;
        logic [79:0] window_pattern;
        window_pattern = "OPENWINDOW";
        rx_shift = '0;
        check_output("idle_valid", 32'(char_valid), 32'd0);
        check_output("idle_busy", 32'(busy), 32'd0);
        start = 1'b1;
        cmd = v.cmd;
        char_ready = 1'b1;
        push_text(v.text);
        tick();
        start = 1'b0;
        cmd = ~v.cmd;
        check_output("first_char_valid", 32'(char_valid), 32'd1);
        transfers = 0;
        busy_cycles = 0;
        finished = 0;
        holding = 0;
        glitched = 0;
        for (int k = 0; k < 200 && !finished; k++) begin
            if (busy) busy_cycles++;
            if (done) begin
                finished = 1;
                check_output("done_valid", 32'(char_valid), 32'd0);
                check_output("done_busy", 32'(busy), 32'd1);
                check_output("done_char", 32'(char), 32'h00);
                check_output("transfer_count", 32'(transfers), 32'(v.text.len()));
                check_output("queue_empty", 32'(exp_q.size()), 32'd0);
            end else begin
                if (holding) begin
                    check_output("hold_char", 32'(char), 32'(held));
                    check_output("hold_valid", 32'(char_valid), 32'd1);
                end
                char_ready = (v.ready_mode == 0) ? 1'b1 : (k % 3 == 0);
                start = 1'b0;
                if (v.glitch_at >= 0 && !glitched && transfers == v.glitch_at) begin
                    start = 1'b1;
                    cmd = 2'd2;
                    glitched = 1;
                end
                holding = 0;
                if (char_valid && char_ready) begin
                    check_transfer("char");
                    rx_shift = {rx_shift[71:0], char};
                    transfers++;
                end else if (char_valid) begin
                    holding = 1;
                    held = char;
                end
                tick();
            end
        end
        start = 1'b0;
        check_output("timeout_done", 32'(finished), 32'd1);
        if (v.ready_mode == 0)
            check_output("busy_cycles", 32'(busy_cycles), 32'(v.text.len() + 1));
        if (v.cmd == 2'd0)
            check_output("loopback_window", 32'(rx_shift == window_pattern), 32'd1);
        tick();
        check_output("after_done_pulse", 32'(done), 32'd0);
        check_output("after_done_busy", 32'(busy), 32'd0);
        tick();
        check_output("no_followup_valid", 32'(char_valid), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        int done_count;
        int done_k;
        int second_k;
        bit seen_done;

        vectors[0] = '{cmd: 2'd0, text: "OPENWINDOW",  ready_mode: 0, glitch_at: -1};
        vectors[1] = '{cmd: 2'd3, text: "CLOSEDOOR",   ready_mode: 1, glitch_at: -1};
        vectors[2] = '{cmd: 2'd1, text: "CLOSEWINDOW", ready_mode: 0, glitch_at: 4};
        vectors[3] = '{cmd: 2'd2, text: "OPENDOOR",    ready_mode: 1, glitch_at: -1};

        reset = 1'b1;
        start = 1'b0;
        cmd = 2'd0;
        char_ready = 1'b0;
        repeat (3) tick();
        check_output("reset_char", 32'(char), 32'h00);
        check_output("reset_valid", 32'(char_valid), 32'd0);
        check_output("reset_busy", 32'(busy), 32'd0);
        check_output("reset_done", 32'(done), 32'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 4; i++) apply_stimulus(vectors[i]);

        // Reset after the fifth OPENWINDOW transfer aborts the command silently.
        start = 1'b1;
        cmd = 2'd0;
        char_ready = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        for (int k = 0; k < 20 && n < 5; k++) begin
            if (char_valid) n++;
            tick();
        end
        check_output("abort_transfers", 32'(n), 32'd5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_output("abort_valid", 32'(char_valid), 32'd0);
        check_output("abort_char", 32'(char), 32'h00);
        check_output("abort_busy", 32'(busy), 32'd0);
        seen_done = 0;
        for (int k = 0; k < 12; k++) begin
            if (done || char_valid) seen_done = 1;
            tick();
        end
        check_output("abort_no_done", 32'(seen_done), 32'd0);

        // Reset wins over start in the same cycle.
        reset = 1'b1;
        start = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        check_output("prio_valid", 32'(char_valid), 32'd0);
        check_output("prio_busy", 32'(busy), 32'd0);
        tick();
        check_output("prio_not_started", 32'(char_valid), 32'd0);

        // Start held high gives back-to-back OPENDOOR separated by DONE plus IDLE.
        start = 1'b1;
        cmd = 2'd2;
        char_ready = 1'b1;
        push_text("OPENDOOR");
        push_text("OPENDOOR");
        tick();
        n = 0;
        done_count = 0;
        done_k = -1;
        second_k = -1;
        for (int k = 0; k < 60 && done_count < 2; k++) begin
            if (done) begin
                done_count++;
                if (done_k < 0) done_k = k;
            end
            if (char_valid) begin
                check_transfer("b2b_char");
                n++;
                if (done_count == 1 && second_k < 0) begin
                    second_k = k;
                    start = 1'b0;
                end
            end
            tick();
        end
        start = 1'b0;
        check_output("b2b_done_count", 32'(done_count), 32'd2);
        check_output("b2b_transfers", 32'(n), 32'd16);
        check_output("b2b_first_done", 32'(done_k), 32'd8);
        check_output("b2b_gap", 32'(second_k - done_k), 32'd2);
        check_output("b2b_queue_empty", 32'(exp_q.size()), 32'd0);
        tick();
        check_output("b2b_idle_valid", 32'(char_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/command_sender.md
COMMAND_SENDER -- requirements
Module: command_sender

Interface
REQ-001 SHALL have parameter IDLE_CHAR, default 8'h00, the character driven on char while char_valid is low.
REQ-002 SHALL have ports: clock  input  1  sole clock, all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to transmit the command on cmd; sampled only in IDLE.
REQ-005 cmd  input  2  command select: 0 OPENWINDOW, 1 CLOSEWINDOW, 2 OPENDOOR, 3 CLOSEDOOR.
REQ-006 char_ready  input  1  downstream accepts char this cycle when high.
REQ-007 char  output  8  ASCII character currently offered.
REQ-008 char_valid  output  1  char holds a valid command character.
REQ-009 busy  output  1  high from the cycle after start is accepted until the cycle done is asserted, inclusive.
REQ-010 done  output  1  one-cycle pulse after the last character is accepted.

Function
REQ-011 SHALL implement FSM states IDLE, SEND, DONE.
REQ-012 IDLE: char_valid=0, char=IDLE_CHAR, busy=0, done=0; start=1 -> latch cmd, clear index, go SEND.
REQ-013 First character SHALL appear on char with char_valid=1 exactly one cycle after the edge that samples start.
REQ-014 SEND: char = ROM[latched cmd][index]; a transfer occurs when char_valid && char_ready at a rising edge.
REQ-015 On a transfer, index SHALL increment; with char_ready low, char and char_valid SHALL hold unchanged (no skip, no repeat).
REQ-016 Command lengths: OPENWINDOW 10, CLOSEWINDOW 11, OPENDOOR 8, CLOSEDOOR 9; characters uppercase ASCII, no terminator.
REQ-017 Transfer of the last character (index = length-1) SHALL move the FSM to DONE.
REQ-018 DONE: char_valid=0, done=1, busy=1 for exactly one cycle, then IDLE unconditionally.
REQ-019 start in SEND or DONE SHALL be ignored; cmd changes after acceptance SHALL NOT affect the command in progress.
REQ-020 start held high continuously SHALL produce back-to-back commands separated by exactly one DONE cycle plus one IDLE cycle.
REQ-021 index SHALL be 4 bits; no wrap-around is reachable since maximum length is 11.

Reset
REQ-022 reset=1 at a rising edge SHALL force IDLE, index=0, char=IDLE_CHAR, char_valid=0, busy=0, done=0, regardless of state.
REQ-023 reset asserted mid-command SHALL abort it with no done pulse; the partial command is not resumed.
REQ-024 reset SHALL have priority over start in the same cycle.

Structure
REQ-025 Shared package smarthouse_pkg SHALL hold command encodings, command lengths and the ASCII constants, shared with the character-recognition receiver.
REQ-026 A combinational sub-module command_rom (inputs cmd, index; output char) SHALL hold the character tables; the FSM, index counter and output registers stay in command_sender.
REQ-027 char, char_valid, busy and done SHALL be driven from registers (no combinational path from char_ready to any output).

Verification
REQ-028 reset 3 cycles, start=1 cmd=0 for one cycle, char_ready=1 -> "O","P","E","N","W","I","N","D","O","W" on consecutive cycles, done one cycle after final "W", busy 11 cycles.
REQ-029 cmd=3, char_ready toggled 1,0,0,1,... -> "CLOSEDOOR" delivered in order, each character held stable while char_ready=0, exactly 9 transfers.
REQ-030 cmd=1 accepted, start=1 with cmd=2 pulsed at transfer 4 -> full "CLOSEWINDOW" sent, second start ignored, no "OPENDOOR" follows.
REQ-031 reset asserted after 5th transfer of OPENWINDOW -> next cycle char_valid=0, char=8'h00, busy=0, no done pulse.
REQ-032 start held high, cmd=2, char_ready=1 -> "OPENDOOR", done, one IDLE cycle, "OPENDOOR" again.
REQ-033 Loopback: command_sender char/char_valid feeding the character-recognition receiver with cmd=0 -> receiver window output asserts after "OPENWINDOW".
